// File: rtl/vga_timing_pkg.sv
// Shared raster timing types, standard VESA modes and helpers for the VGA timing generator.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_timing_t;

  typedef struct packed {
    vga_timing_t h;
    vga_timing_t v;
  } vga_mode_t;

  localparam vga_mode_t VGA_640x480_60 = '{'{640, 16, 96, 48}, '{480, 10, 2, 33}};
  localparam vga_mode_t VGA_800x600_60 = '{'{800, 40, 128, 88}, '{600, 1, 4, 23}};

  localparam int unsigned DEFAULT_CNT_W = 12;

  function automatic int unsigned axis_total(input vga_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster output bundle from the timing generator towards the VGA pins / pixel source.
interface vga_timing_if
  import vga_timing_pkg::*;
#(
  parameter int unsigned CNT_W   = DEFAULT_CNT_W,
  parameter int unsigned FRAME_W = 8
);
  logic               hsync;
  logic               vsync;
  logic               v_on;
  logic [CNT_W-1:0]   x;
  logic [CNT_W-1:0]   y;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;
  logic [7:0]         tp_r;
  logic [7:0]         tp_g;
  logic [7:0]         tp_b;

  modport master (
    output hsync, vsync, v_on, x, y, line_start, frame_start, frame_cnt, tp_r, tp_g, tp_b
  );

  modport slave (
    input hsync, vsync, v_on, x, y, line_start, frame_start, frame_cnt, tp_r, tp_g, tp_b
  );
endinterface

// File: rtl/vtg_delay_line.sv
// Clock-enabled shift register with synchronous reset to a configurable value; DEPTH=0 is a wire.
module vtg_delay_line #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, en};
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin : p_shift
      if (rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
      end else if (en) begin
        stage_q[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA raster timing generator with aligned output delay line.
// Optional colour-bar test pattern enabled by defining VGA_TIMING_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_640x480_60.h.active,
  parameter int unsigned H_FP     = VGA_640x480_60.h.fp,
  parameter int unsigned H_SYNC   = VGA_640x480_60.h.sync,
  parameter int unsigned H_BP     = VGA_640x480_60.h.bp,
  parameter int unsigned V_ACTIVE = VGA_640x480_60.v.active,
  parameter int unsigned V_FP     = VGA_640x480_60.v.fp,
  parameter int unsigned V_SYNC   = VGA_640x480_60.v.sync,
  parameter int unsigned V_BP     = VGA_640x480_60.v.bp,
  parameter logic        H_POL    = 1'b0,
  parameter logic        V_POL    = 1'b0,
  parameter int unsigned CNT_W    = DEFAULT_CNT_W,
  parameter int unsigned FRAME_W  = 8,
  parameter int unsigned PIPE_DLY = 0
) (
  input logic          pll_clk,
  input logic          reset_P,
  input logic          en,
  vga_timing_if.master vga
);

  localparam vga_timing_t H_TIM   = '{H_ACTIVE, H_FP, H_SYNC, H_BP};
  localparam vga_timing_t V_TIM   = '{V_ACTIVE, V_FP, V_SYNC, V_BP};
  localparam int unsigned H_TOTAL = axis_total(H_TIM);
  localparam int unsigned V_TOTAL = axis_total(V_TIM);

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Flattened output word: {hsync, vsync, v_on, line_start, frame_start, x, y, frame_cnt, r, g, b}
  localparam int unsigned       PW      = 5 + 2 * CNT_W + FRAME_W + 24;
  localparam int unsigned       LS_BIT  = PW - 4;
  localparam int unsigned       FS_BIT  = PW - 5;
  localparam logic [PW-1:0]     RST_VEC = {~H_POL, ~V_POL, {(PW - 2){1'b0}}};

  if (H_SYNC == 0 || V_SYNC == 0) begin : g_err_sync
    $error("vga_timing_gen: sync width must be non-zero");
  end
  if (PIPE_DLY > 7) begin : g_err_dly
    $error("vga_timing_gen: PIPE_DLY must be 0..7");
  end
  if (H_TOTAL > 2 ** CNT_W || V_TOTAL > 2 ** CNT_W) begin : g_err_cnt
    $error("vga_timing_gen: CNT_W too small for line/frame totals");
  end

  logic [CNT_W-1:0]   h_q;
  logic [CNT_W-1:0]   v_q;
  logic [FRAME_W-1:0] frame_q;

  // Raster counters; frame counter ticks when the last pixel of the frame retires.
  always_ff @(posedge pll_clk) begin : p_cnt
    if (reset_P) begin
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= '0;
    end else if (en) begin
      if (h_q == H_LAST) begin
        h_q <= '0;
        if (v_q == V_LAST) begin
          v_q     <= '0;
          frame_q <= frame_q + FRAME_W'(1);
        end else begin
          v_q <= v_q + CNT_W'(1);
        end
      end else begin
        h_q <= h_q + CNT_W'(1);
      end
    end
  end

  logic       hs_c, vs_c, de_c, ls_c, fs_c;
  logic [7:0] tp_r_c, tp_g_c, tp_b_c;

  assign hs_c = (h_q >= HS_BEG && h_q < HS_END) ? H_POL : ~H_POL;
  assign vs_c = (v_q >= VS_BEG && v_q < VS_END) ? V_POL : ~V_POL;
  assign de_c = (h_q < H_ACT_C) && (v_q < V_ACT_C);
  assign ls_c = (h_q == '0);
  assign fs_c = ls_c && (v_q == '0);

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  logic [2:0] bar_c;

  // Bar index by threshold compare; bar 7 absorbs the remainder of the line.
  always_comb begin : p_bar
    bar_c = 3'd0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (h_q >= CNT_W'(k * BAR_W)) bar_c = 3'(k);
    end
  end

  always_comb begin : p_tp
    tp_r_c = 8'h00;
    tp_g_c = 8'h00;
    tp_b_c = 8'h00;
    if (de_c) begin
      tp_r_c = {8{~bar_c[1]}};
      tp_g_c = {8{~bar_c[2]}};
      tp_b_c = {8{~bar_c[0]}};
    end
  end
`else
  assign tp_r_c = 8'h00;
  assign tp_g_c = 8'h00;
  assign tp_b_c = 8'h00;
`endif

  logic [PW-1:0] pix_c;
  logic [PW-1:0] dl_q;
  logic [PW-1:0] out_q;

  assign pix_c = {hs_c, vs_c, de_c, ls_c, fs_c, h_q, v_q, frame_q, tp_r_c, tp_g_c, tp_b_c};

  vtg_delay_line #(
    .WIDTH  (PW),
    .DEPTH  (PIPE_DLY),
    .RST_VAL(RST_VEC)
  ) u_dly (
    .clk(pll_clk),
    .rst(reset_P),
    .en (en),
    .d  (pix_c),
    .q  (dl_q)
  );

  // Output register; strobes drop while en is low so a pulse never repeats.
  always_ff @(posedge pll_clk) begin : p_out
    if (reset_P) begin
      out_q <= RST_VEC;
    end else if (en) begin
      out_q <= dl_q;
    end else begin
      out_q[LS_BIT] <= 1'b0;
      out_q[FS_BIT] <= 1'b0;
    end
  end

  assign {vga.hsync, vga.vsync, vga.v_on, vga.line_start, vga.frame_start,
          vga.x, vga.y, vga.frame_cnt, vga.tp_r, vga.tp_g, vga.tp_b} = out_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen: default 640x480, delayed twin and a tiny raster.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic pll_clk = 1'b0;
  logic reset_P = 1'b1;
  logic en      = 1'b0;
  int   n_cmp   = 0;
  int   n_err   = 0;

  always #5 pll_clk = ~pll_clk;

  vga_timing_if #(.CNT_W(12), .FRAME_W(8)) if0 ();
  vga_timing_if #(.CNT_W(12), .FRAME_W(8)) if3 ();
  vga_timing_if #(.CNT_W(12), .FRAME_W(2)) ifs ();

  vga_timing_gen #(.PIPE_DLY(0)) u0 (.pll_clk(pll_clk), .reset_P(reset_P), .en(en), .vga(if0));
  vga_timing_gen #(.PIPE_DLY(3)) u3 (.pll_clk(pll_clk), .reset_P(reset_P), .en(en), .vga(if3));
  // Tiny raster: 24 pixels/line (hsync x=18..20), 11 lines/frame (vsync y=7..8), 264 cycles/frame
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b1), .V_POL(1'b1), .FRAME_W(2), .PIPE_DLY(0)
  ) us (.pll_clk(pll_clk), .reset_P(reset_P), .en(en), .vga(ifs));

  function automatic logic [60:0] snap0();
    return {if0.hsync, if0.vsync, if0.v_on, if0.line_start, if0.frame_start,
            if0.x, if0.y, if0.frame_cnt, if0.tp_r, if0.tp_g, if0.tp_b};
  endfunction

  function automatic logic [60:0] snap3();
    return {if3.hsync, if3.vsync, if3.v_on, if3.line_start, if3.frame_start,
            if3.x, if3.y, if3.frame_cnt, if3.tp_r, if3.tp_g, if3.tp_b};
  endfunction

  task automatic tick();
    @(posedge pll_clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset_P = 1'b1;
    en      = 1'b1;
    repeat (cycles) tick();
    reset_P = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(5);
    n_cmp++;
    if ({if0.hsync, if0.vsync, if0.v_on, if0.line_start, if0.frame_start} !== 5'b11000) begin
      n_err++;
      $display("FAIL reset_u0_ctl: got %b want 11000",
               {if0.hsync, if0.vsync, if0.v_on, if0.line_start, if0.frame_start});
    end
    n_cmp++;
    if ({if0.x, if0.y, if0.frame_cnt} !== 32'd0) begin
      n_err++;
      $display("FAIL reset_u0_cnt: got x=%0d y=%0d f=%0d want 0", if0.x, if0.y, if0.frame_cnt);
    end
    n_cmp++;
    if ({if0.tp_r, if0.tp_g, if0.tp_b} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_u0_tp: got %h want 000000", {if0.tp_r, if0.tp_g, if0.tp_b});
    end
    n_cmp++;
    if (snap3() !== {5'b11000, 56'd0}) begin
      n_err++;
      $display("FAIL reset_u3: got %h want %h", snap3(), {5'b11000, 56'd0});
    end
    n_cmp++;
    if ({ifs.hsync, ifs.vsync, ifs.v_on, ifs.line_start, ifs.frame_start} !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_us_idle: got %b want 00000",
               {ifs.hsync, ifs.vsync, ifs.v_on, ifs.line_start, ifs.frame_start});
    end
  endtask

  // Default timing: hsync 657 cycles after reset, width 96, period 800; PIPE_DLY=3 twin lags 3 cycles.
  task automatic test_hsync_twin();
    int first_on, first_off, second_on;
    logic prev_hs;
    logic [60:0] hist [$];
    first_on = -1; first_off = -1; second_on = -1;
    do_reset(5);
    prev_hs = if0.hsync;
    hist.push_back(snap0());
    for (int n = 1; n <= 1700; n++) begin
      tick();
      if (prev_hs && !if0.hsync) begin
        if (first_on < 0) first_on = n;
        else if (second_on < 0) second_on = n;
      end
      if (!prev_hs && if0.hsync && first_off < 0) first_off = n;
      prev_hs = if0.hsync;
      hist.push_back(snap0());
      if (n == 1) begin
        n_cmp++;
        if ({if0.v_on, if0.line_start, if0.frame_start, if0.x, if0.y} !== {3'b111, 24'd0}) begin
          n_err++;
          $display("FAIL first_pixel: got de/ls/fs=%b%b%b x=%0d y=%0d want 111 x=0 y=0",
                   if0.v_on, if0.line_start, if0.frame_start, if0.x, if0.y);
        end
      end
      if (n == 2) begin
        n_cmp++;
        if ({if0.line_start, if0.frame_start, if0.x} !== {2'b00, 12'd1}) begin
          n_err++;
          $display("FAIL second_pixel: got ls/fs=%b%b x=%0d want 00 x=1",
                   if0.line_start, if0.frame_start, if0.x);
        end
      end
      if (n == 641) begin
        n_cmp++;
        if (if0.v_on !== 1'b0 || if0.x !== 12'd640) begin
          n_err++;
          $display("FAIL de_end: got v_on=%b x=%0d want 0 x=640", if0.v_on, if0.x);
        end
      end
      if (n >= 3) begin
        n_cmp++;
        if (snap3() !== hist[n-3]) begin
          n_err++;
          $display("FAIL twin_dly3 n=%0d: got %h want %h", n, snap3(), hist[n-3]);
        end
      end
    end
    n_cmp++;
    if (first_on != 657) begin
      n_err++;
      $display("FAIL hsync_first: got %0d want 657", first_on);
    end
    n_cmp++;
    if (first_off - first_on != 96) begin
      n_err++;
      $display("FAIL hsync_width: got %0d want 96", first_off - first_on);
    end
    n_cmp++;
    if (second_on - first_on != 800) begin
      n_err++;
      $display("FAIL hsync_period: got %0d want 800", second_on - first_on);
    end
  endtask

  // Tiny raster: vsync lines, frame_start period, frame_cnt wrap 3->0, active-high hsync.
  task automatic test_frame();
    int fs_seen, vs_cnt, vs_y;
    fs_seen = 0; vs_cnt = 0; vs_y = -1;
    do_reset(3);
    for (int n = 1; n <= 1100; n++) begin
      tick();
      if (ifs.vsync === 1'b1) begin
        if (n <= 264) vs_cnt++;
        if (vs_y < 0) vs_y = int'(ifs.y);
      end
      if (n == 1 || n == 19) begin
        n_cmp++;
        if (ifs.hsync !== (n == 19)) begin
          n_err++;
          $display("FAIL us_hsync n=%0d: got %b want %b", n, ifs.hsync, (n == 19));
        end
      end
      if (ifs.frame_start === 1'b1) begin
        n_cmp++;
        if (n != 1 + fs_seen * 264 || ifs.frame_cnt !== 2'(fs_seen) || ifs.x !== 12'd0 || ifs.y !== 12'd0) begin
          n_err++;
          $display("FAIL frame_start #%0d: got n=%0d cnt=%0d x=%0d y=%0d want n=%0d cnt=%0d x=0 y=0",
                   fs_seen, n, ifs.frame_cnt, ifs.x, ifs.y, 1 + fs_seen * 264, fs_seen % 4);
        end
        fs_seen++;
      end
    end
    n_cmp++;
    if (fs_seen != 5) begin
      n_err++;
      $display("FAIL frame_count: got %0d pulses want 5", fs_seen);
    end
    n_cmp++;
    if (vs_y != 7 || vs_cnt != 48) begin
      n_err++;
      $display("FAIL vsync: got y=%0d len=%0d want y=7 len=48", vs_y, vs_cnt);
    end
  endtask

  // en high on every other cycle: x advances once per enabled edge, periods double.
  task automatic test_en_half();
    int k, hs_on, hs_off, hs_on2, exp_x;
    logic prev_hs, exp_ls;
    k = 0; hs_on = -1; hs_off = -1; hs_on2 = -1;
    do_reset(2);
    prev_hs = if0.hsync;
    for (int n = 1; n <= 3000; n++) begin
      en = (n % 2 == 1);
      tick();
      if (en) k++;
      exp_x  = (k == 0) ? 0 : (k - 1) % 800;
      exp_ls = en && (k > 0) && ((k - 1) % 800 == 0);
      n_cmp++;
      if (if0.x !== 12'(exp_x) || if0.line_start !== exp_ls) begin
        n_err++;
        $display("FAIL en_half n=%0d: got x=%0d ls=%b want x=%0d ls=%b", n, if0.x, if0.line_start, exp_x, exp_ls);
      end
      if (prev_hs && !if0.hsync) begin
        if (hs_on < 0) hs_on = n;
        else if (hs_on2 < 0) hs_on2 = n;
      end
      if (!prev_hs && if0.hsync && hs_off < 0) hs_off = n;
      prev_hs = if0.hsync;
    end
    en = 1'b1;
    n_cmp++;
    if (hs_on != 1313 || hs_off - hs_on != 192 || hs_on2 - hs_on != 1600) begin
      n_err++;
      $display("FAIL en_half_hsync: got on=%0d width=%0d period=%0d want 1313 192 1600",
               hs_on, hs_off - hs_on, hs_on2 - hs_on);
    end
  endtask

  // Mid-frame reset at tiny-raster x=10,y=3: immediate reset outputs, clean restart, twin stages cleared.
  task automatic test_mid_reset();
    bit found;
    found = 1'b0;
    do_reset(2);
    for (int n = 0; n < 400 && !found; n++) begin
      tick();
      if (ifs.x == 12'd10 && ifs.y == 12'd3) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL mid_reset_reach: got not reached want x=10 y=3 within 400 cycles");
    end
    reset_P = 1'b1;
    tick();
    reset_P = 1'b0;
    n_cmp++;
    if ({ifs.hsync, ifs.vsync, ifs.v_on, ifs.line_start, ifs.frame_start, ifs.x, ifs.y, ifs.frame_cnt} !== 31'd0) begin
      n_err++;
      $display("FAIL mid_reset_us: got x=%0d y=%0d hs=%b de=%b want all reset", ifs.x, ifs.y, ifs.hsync, ifs.v_on);
    end
    n_cmp++;
    if (snap0() !== {5'b11000, 56'd0}) begin
      n_err++;
      $display("FAIL mid_reset_u0: got %h want %h", snap0(), {5'b11000, 56'd0});
    end
    for (int n = 1; n <= 4; n++) begin
      tick();
      n_cmp++;
      if ({if3.v_on, if3.frame_start} !== ((n == 4) ? 2'b11 : 2'b00) || if3.x !== 12'd0) begin
        n_err++;
        $display("FAIL mid_reset_u3 n=%0d: got de=%b fs=%b x=%0d want %b x=0",
                 n, if3.v_on, if3.frame_start, if3.x, (n == 4) ? 2'b11 : 2'b00);
      end
      if (n == 1) begin
        n_cmp++;
        if ({ifs.frame_start, ifs.x, ifs.y, if0.frame_start, if0.x} !== {1'b1, 24'd0, 1'b1, 12'd0}) begin
          n_err++;
          $display("FAIL mid_reset_restart: got us fs=%b x=%0d y=%0d u0 fs=%b x=%0d want fs=1 x=0 y=0",
                   ifs.frame_start, ifs.x, ifs.y, if0.frame_start, if0.x);
        end
      end
    end
  endtask

  // Colour bars along line 0 of the default raster (all zero when the pattern is not built).
  task automatic test_pattern();
    int xs [11];
    logic [23:0] tps [11];
    logic [23:0] exp_tp;
    int idx;
    xs  = '{0, 79, 80, 160, 240, 320, 400, 480, 560, 639, 700};
    tps = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF,
            24'hFF0000, 24'h0000FF, 24'h000000, 24'h000000, 24'h000000};
    idx = 0;
    do_reset(2);
    for (int n = 1; n <= 701; n++) begin
      tick();
      if (idx < 11 && if0.x == 12'(xs[idx])) begin
`ifdef VGA_TIMING_TEST_PATTERN_EN
        exp_tp = tps[idx];
`else
        exp_tp = 24'h000000;
`endif
        n_cmp++;
        if ({if0.tp_r, if0.tp_g, if0.tp_b} !== exp_tp) begin
          n_err++;
          $display("FAIL tp x=%0d: got %h want %h", xs[idx], {if0.tp_r, if0.tp_g, if0.tp_b}, exp_tp);
        end
        idx++;
      end
    end
    n_cmp++;
    if (idx != 11) begin
      n_err++;
      $display("FAIL tp_coverage: got %0d points want 11", idx);
    end
  endtask

  initial begin
    test_reset();
    test_hsync_twin();
    test_frame();
    test_en_half();
    test_mid_reset();
    test_pattern();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
